// File: rtl/oib_pkg.sv
// Shared constants, FSM state type and parity helper for the oib byte-bus responder.
package oib_pkg;

    localparam int unsigned OIB_HDR_START = 7;

    localparam logic [7:0] OIB_RSP_WACK = 8'h80;
    localparam logic [7:0] OIB_RSP_RACK = 8'h81;
    localparam logic [7:0] OIB_RSP_TMO  = 8'h82;
    localparam logic [7:0] OIB_IDLE     = 8'h00;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StBus,
        StRespHdr,
        StRespData
    } oib_state_e;

    // Odd parity: XOR over data plus parity bit is 1.
    function automatic logic odd_pty(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/oib_target_if.sv
// Byte-lane and Wishbone signal bundle of the oib responder; master is the responder side.
interface oib_target_if;

    logic [7:0]  rx_data;
    logic        rx_pty;
    logic [7:0]  tx_data;
    logic        tx_pty;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        parity_err;
    logic        timeout_err;

    modport master (
        input  rx_data, rx_pty, wb_dat_i, wb_ack_i,
        output tx_data, tx_pty, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output parity_err, timeout_err
    );

    modport slave (
        output rx_data, rx_pty, wb_dat_i, wb_ack_i,
        input  tx_data, tx_pty, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  parity_err, timeout_err
    );

endinterface

// File: rtl/oib_resp_serializer.sv
// Response shifter: load puts the header on the lane, each shift emits the next data byte LSB
// first, and any cycle without load or shift returns the lane to the idle byte.
module oib_resp_serializer
    import oib_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  logic [7:0]  hdr,
    input  logic [31:0] data,
    output logic [7:0]  tx_data,
    output logic        tx_pty
);

    logic [7:0]  tx_q, tx_d;
    logic        pty_q;
    logic [31:0] data_q, data_d;

    always_comb begin
        tx_d   = OIB_IDLE;
        data_d = data_q;
        if (load) begin
            tx_d   = hdr;
            data_d = data;
        end else if (shift) begin
            tx_d   = data_q[7:0];
            data_d = {8'h00, data_q[31:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q   <= OIB_IDLE;
            pty_q  <= 1'b1;
            data_q <= '0;
        end else begin
            tx_q   <= tx_d;
            pty_q  <= odd_pty(tx_d);
            data_q <= data_d;
        end
    end

    assign tx_data = tx_q;
    assign tx_pty  = pty_q;

endmodule

// File: rtl/oib_target.sv
// oib responder: deframes requests from the outbound lane, runs one Wishbone classic cycle per
// request and answers on the inbound lane with an ack, read data or a timeout header.
module oib_target
    import oib_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    oib_target_if.master bus
);

    oib_state_e  state_q, state_d;
    logic [7:0]  rx_data_q;
    logic        rx_pty_q;
    logic        rx_good;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_data_q, rsp_data_d;
    logic        perr_q, perr_d;
    logic        terr_q, terr_d;

    logic        ser_load;
    logic        ser_shift;
    logic [7:0]  ser_hdr;
    logic [31:0] ser_data;

    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

    // Input byte is registered first; the FSM only ever looks at this copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q <= OIB_IDLE;
            rx_pty_q  <= 1'b1;
        end else begin
            rx_data_q <= bus.rx_data;
            rx_pty_q  <= bus.rx_pty;
        end
    end

    assign rx_good = ^{rx_data_q, rx_pty_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rsp_data_d = rsp_data_q;
        perr_d     = perr_q;
        terr_d     = terr_q;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        ser_hdr    = OIB_IDLE;
        ser_data   = '0;

        unique case (state_q)
            StIdle: begin
                if (rx_data_q[OIB_HDR_START]) begin
                    if (rx_good) begin
                        we_d    = rx_data_q[0];
                        sel_d   = rx_data_q[4:1];
                        cnt_d   = 2'd0;
                        state_d = StAddr;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            StAddr: begin
                if (!rx_good) begin
                    perr_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    adr_d[{cnt_q, 3'b000} +: 8] = rx_data_q;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        tmo_d   = '0;
                        state_d = we_q ? StWdata : StBus;
                    end
                end
            end
            StWdata: begin
                if (!rx_good) begin
                    perr_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    dat_d[{cnt_q, 3'b000} +: 8] = rx_data_q;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        tmo_d   = '0;
                        state_d = StBus;
                    end
                end
            end
            StBus: begin
                tmo_d = tmo_q + 16'd1;
                // Ack is checked first so it wins over a coincident expiry.
                if (bus.wb_ack_i) begin
                    ser_load   = 1'b1;
                    ser_hdr    = we_q ? OIB_RSP_WACK : OIB_RSP_RACK;
                    ser_data   = bus.wb_dat_i;
                    rsp_data_d = !we_q;
                    state_d    = StRespHdr;
                end else if (tmo_q == TmoLast) begin
                    ser_load   = 1'b1;
                    ser_hdr    = OIB_RSP_TMO;
                    rsp_data_d = 1'b0;
                    terr_d     = 1'b1;
                    state_d    = StRespHdr;
                end
            end
            StRespHdr: begin
                if (rsp_data_q) begin
                    ser_shift = 1'b1;
                    cnt_d     = 2'd0;
                    state_d   = StRespData;
                end else begin
                    state_d = StIdle;
                end
            end
            StRespData: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q != 2'd3) begin
                    ser_shift = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rsp_data_q <= 1'b0;
            perr_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rsp_data_q <= rsp_data_d;
            perr_q     <= perr_d;
            terr_q     <= terr_d;
        end
    end

    oib_resp_serializer u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (ser_load),
        .shift   (ser_shift),
        .hdr     (ser_hdr),
        .data    (ser_data),
        .tx_data (bus.tx_data),
        .tx_pty  (bus.tx_pty)
    );

    assign bus.wb_cyc_o    = (state_q == StBus);
    assign bus.wb_stb_o    = (state_q == StBus);
    assign bus.wb_we_o     = we_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.parity_err  = perr_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_oib_target.sv
// Directed bench for oib_target: request frames in, Wishbone slave responses, and a
// scoreboard of expected response bytes checked as they leave the inbound lane.
module tb_oib_target;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oib_target_if bus ();

    oib_target #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       pty;
    } rsp_byte_t;

    int          checks = 0;
    int          errors = 0;
    rsp_byte_t   exp_q[$];
    logic [7:0]  frame[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pty_of(input logic [7:0] b);
        return ~^b;
    endfunction

    // Drive the current frame one byte per cycle; flip_idx selects a byte with bad parity.
    task automatic send_frame(input int flip_idx);
        for (int i = 0; i < frame.size(); i++) begin
            bus.rx_data = frame[i];
            bus.rx_pty  = pty_of(frame[i]) ^ (i == flip_idx);
            tick();
        end
        bus.rx_data = 8'h00;
        bus.rx_pty  = 1'b1;
    endtask

    // Called in the cycle after the last byte: cyc must still be low, then high one cycle later.
    task automatic expect_bus_start(input string tag);
        check({tag, "_cyc_n1"}, bus.wb_cyc_o, 1'b0);
        tick();
        check({tag, "_cyc_n2"}, {bus.wb_cyc_o, bus.wb_stb_o}, 2'b11);
    endtask

    task automatic push_rsp(input logic [7:0] hdr, input bit has_data, input logic [31:0] d);
        exp_q.push_back('{data: hdr, pty: pty_of(hdr)});
        if (has_data) begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] b;
                b = d[8*i +: 8];
                exp_q.push_back('{data: b, pty: pty_of(b)});
            end
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            rsp_byte_t e;
            e = exp_q.pop_front();
            check({tag, "_tx"}, {bus.tx_data, bus.tx_pty}, {e.data, e.pty});
            tick();
        end
        check({tag, "_idle"}, {bus.tx_data, bus.tx_pty}, {8'h00, 1'b1});
    endtask

    // Starting in the first BUS cycle: ack after `delay` cycles, then check the response.
    task automatic serve(input string tag, input int delay, input logic [31:0] rdata);
        for (int i = 0; i < delay; i++) tick();
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = rdata;
        tick();
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 32'h0;
        check({tag, "_cyc_drop"}, bus.wb_cyc_o, 1'b0);
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        bus.rx_data  = 8'h00;
        bus.rx_pty   = 1'b1;
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 32'h0;

        tick();
        tick();
        check("rst_tx", {bus.tx_data, bus.tx_pty}, {8'h00, 1'b1});
        check("rst_wb", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o}, 7'h00);
        check("rst_adr_dat", {bus.wb_adr_o, bus.wb_dat_o}, 64'h0);
        check("rst_err", {bus.parity_err, bus.timeout_err}, 2'b00);
        rst = 1'b0;
        tick();

        // Write with ack after 2 cycles.
        frame = '{8'h9F, 8'h10, 8'h00, 8'h00, 8'h30, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        push_rsp(8'h80, 1'b0, 32'h0);
        send_frame(-1);
        expect_bus_start("wr");
        check("wr_adr", bus.wb_adr_o, 32'h3000_0010);
        check("wr_dat", bus.wb_dat_o, 32'hDEAD_BEEF);
        check("wr_sel_we", {bus.wb_sel_o, bus.wb_we_o}, 5'b1111_1);
        serve("wr", 2, 32'h0);

        // Read with immediate ack.
        frame = '{8'h9E, 8'h20, 8'h00, 8'h00, 8'h30};
        push_rsp(8'h81, 1'b1, 32'h1234_5678);
        send_frame(-1);
        expect_bus_start("rd");
        check("rd_adr", bus.wb_adr_o, 32'h3000_0020);
        check("rd_sel_we", {bus.wb_sel_o, bus.wb_we_o}, 5'b1111_0);
        serve("rd", 0, 32'h1234_5678);

        // Ack lands in the last cycle before expiry: read data, no timeout flag.
        frame = '{8'h86, 8'h44, 8'h33, 8'h22, 8'h11};
        push_rsp(8'h81, 1'b1, 32'hA5C3_0F96);
        send_frame(-1);
        expect_bus_start("ackexp");
        check("ackexp_sel", bus.wb_sel_o, 4'b0011);
        serve("ackexp", 7, 32'hA5C3_0F96);
        check("ackexp_terr", bus.timeout_err, 1'b0);

        // Parity error on the third address byte: frame dropped silently.
        frame = '{8'h9E, 8'h20, 8'h00, 8'h00, 8'h30};
        send_frame(3);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.wb_cyc_o || bus.tx_data != 8'h00) seen = 1'b1;
            tick();
        end
        check("perr_quiet", seen, 1'b0);
        check("perr_flag", {bus.parity_err, bus.timeout_err}, 2'b10);

        frame = '{8'h9F, 8'h04, 8'h00, 8'h00, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
        push_rsp(8'h80, 1'b0, 32'h0);
        send_frame(-1);
        expect_bus_start("perr_next");
        check("perr_next_adr", bus.wb_adr_o, 32'h4000_0004);
        check("perr_next_dat", bus.wb_dat_o, 32'h0403_0201);
        serve("perr_next", 1, 32'h0);

        // Timeout: slave never acks.
        frame = '{8'h9E, 8'h00, 8'h01, 8'h00, 8'h50};
        push_rsp(8'h82, 1'b0, 32'h0);
        send_frame(-1);
        expect_bus_start("tmo");
        n = 0;
        while (bus.wb_stb_o && n < 40) begin
            n++;
            tick();
        end
        check("tmo_stb_len", n, 8);
        check("tmo_cyc_low", bus.wb_cyc_o, 1'b0);
        check("tmo_flag", bus.timeout_err, 1'b1);
        drain("tmo");

        // Reset while the bus cycle is open.
        frame = '{8'h9E, 8'h08, 8'h00, 8'h00, 8'h60};
        send_frame(-1);
        expect_bus_start("rstbus");
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rstbus_cyc", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b00);
        check("rstbus_tx", {bus.tx_data, bus.tx_pty}, {8'h00, 1'b1});
        check("rstbus_err", {bus.parity_err, bus.timeout_err}, 2'b00);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.wb_cyc_o || bus.tx_data != 8'h00) seen = 1'b1;
        end
        check("rstbus_quiet", seen, 1'b0);

        frame = '{8'h9E, 8'h0C, 8'h00, 8'h00, 8'h60};
        push_rsp(8'h81, 1'b1, 32'hCAFE_F00D);
        send_frame(-1);
        expect_bus_start("after_rst");
        serve("after_rst", 1, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oib_target.md
# oib_target

Off-chip byte-bus responder: the far end of the core's 8-bit parity-protected outbound/inbound bus (oib). It deframes request packets arriving on the core's outbound lane and runs one classic Wishbone master cycle per request. It then returns an acknowledge or read-data packet on the core's inbound lane. It sits in the companion FPGA/peripheral die, clocked by the bus clock `oib_clk`.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles `wb_stb_o` may stay high without `wb_ack_i` before the request is aborted. Range 1..65535.
- `clk` in 1: bus clock (`oib_clk` from initiator)
- `rst` in 1: reset, synchronous, active-high
- `rx_data` in 8: request byte lane (initiator ob_data)
- `rx_pty` in 1: odd parity for `rx_data`
- `tx_data` out 8: response byte lane (initiator ib_data), registered
- `tx_pty` out 1: odd parity for `tx_data`, registered
- `wb_cyc_o`, `wb_stb_o` out 1: Wishbone cycle/strobe
- `wb_we_o` out 1: write enable
- `wb_sel_o` out 4: byte selects
- `wb_adr_o` out 32: byte address
- `wb_dat_o` out 32: write data
- `wb_dat_i` in 32: read data
- `wb_ack_i` in 1: acknowledge
- `parity_err` out 1: sticky, request byte failed parity
- `timeout_err` out 1: sticky, Wishbone timeout occurred

## Operation
Parity is odd: `pty = ~^data`, so the XOR of all 9 bits is 1. Idle byte is 0x00 with pty=1.

Request frame, bytes on consecutive cycles:
- Header: bit7=1; bits[4:1]=sel; bit0=we; bits[6:5] reserved and ignored.
- Four address bytes, LSB first.
- If we=1, four write-data bytes, LSB first.

Response frame, bytes on consecutive cycles:
- 0x80: write ack, header only.
- 0x81: read ack, followed by 4 data bytes, LSB first.
- 0x82: timeout, header only.

Input path:
- `rx_data`/`rx_pty` are registered into `rx_q` first. The FSM consumes only `rx_q`.

FSM states: IDLE, ADDR, WDATA, BUS, RESP_HDR, RESP_DATA. A 2-bit byte counter serves ADDR, WDATA and RESP_DATA.
- IDLE: `rx_q` with bit7=1 and good parity latches we/sel, then goes to ADDR. Other bytes are ignored. A bit7=1 byte with bad parity sets `parity_err` and stays in IDLE.
- ADDR: takes 4 bytes. Then goes to WDATA if we=1, else to BUS.
- WDATA: takes 4 bytes, then goes to BUS.
- Bad parity on any ADDR/WDATA byte: set `parity_err`, discard the frame, return to IDLE. No bus cycle and no response are generated.
- BUS: `wb_cyc_o`=`wb_stb_o`=1, with adr/dat/sel/we held stable.
  - On `wb_ack_i`: drop cyc/stb on the next edge, capture `wb_dat_i` if read, go to RESP_HDR.
  - If the timeout counter reaches `TIMEOUT_CYCLES` without ack: drop cyc/stb, set `timeout_err`, send response 0x82.
  - Ack in the same cycle as expiry: ack wins.
- RESP_HDR drives the header byte. RESP_DATA drives 4 read bytes (reads only). Then return to IDLE with tx idle.
- Bytes received outside IDLE/ADDR/WDATA are ignored. The initiator has at most one outstanding request.

## Timing
- Reset values:
  - `tx_data`=0x00, `tx_pty`=1.
  - All `wb_*_o` = 0.
  - `parity_err`=`timeout_err`=0.
  - FSM in IDLE, counters 0.
- `rst` during any state aborts the operation: `wb_cyc_o` is low from the next edge and no response is sent.
- Request latency:
  - Last request byte is present at `rx_data` in cycle n.
  - It is in `rx_q` at n+1.
  - `wb_cyc_o`/`wb_stb_o` are high from n+2.
- Response latency:
  - `wb_ack_i` is sampled high in cycle m.
  - Response header appears on `tx_data` in cycle m+1.
  - Read data occupies m+2..m+5.
  - Idle from m+2 (write) or m+6 (read).
- Timeout counter starts at 0 on BUS entry and increments every BUS cycle. Expiry occurs in cycle TIMEOUT_CYCLES after `wb_stb_o` rises.
- Minimum request-to-next-header spacing is decided by the initiator; the block is ready in IDLE the cycle after the response ends.

## Structure
- Package `oib_pkg` holds:
  - header constants: `OIB_HDR_START` bit, `OIB_RSP_WACK`=0x80, `OIB_RSP_RACK`=0x81, `OIB_RSP_TMO`=0x82, `OIB_IDLE`=0x00;
  - the FSM state enum;
  - the odd-parity function.
- Sub-module `oib_resp_serializer`: loads header plus optional 32-bit data, and shifts out header then bytes with parity.

## Test plan
- Write: frame 0x9F, 0x10,0x00,0x00,0x30, 0xEF,0xBE,0xAD,0xDE, with slave ack after 2 cycles. Required response:
  - `wb_adr_o`=0x30000010, `wb_dat_o`=0xDEADBEEF, `wb_sel_o`=0xF, `wb_we_o`=1;
  - tx 0x80 (pty 0) one cycle after ack, then 0x00.
- Read: frame 0x9E, addr 0x30000020, slave returns 0x12345678 with immediate ack. Required response:
  - tx 0x81, 0x78, 0x56, 0x34, 0x12, with correct parity.
  - cyc rises 2 cycles after the last address byte.
- Parity error: flip `rx_pty` on the third address byte. Required response: no `wb_cyc_o`, no response, `parity_err`=1. The next good frame still completes normally.
- Timeout: `TIMEOUT_CYCLES`=8 and the slave never acks. Required response: stb high for exactly 8 cycles, tx 0x82, `timeout_err`=1.
- Ack and timeout in the same cycle: required response is tx 0x81 with data, and `timeout_err` stays 0.
- Reset mid-BUS: required response is cyc low the next cycle, tx 0x00/pty 1, and the FSM in IDLE.
